// File: rtl/servile_wb_rr_arbiter.sv
// Three-master round-robin Wishbone arbiter in front of the shared SRAM port.
// Grants one request at a time, holds the slave request steady, and force-completes hung slaves.
`timescale 1ns/1ps
module servile_wb_rr_arbiter #(
  parameter int aw      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-3:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_stb,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  input  logic [aw-3:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_stb,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  input  logic [aw-3:0] i_m2_adr,
  input  logic [31:0]   i_m2_dat,
  input  logic [3:0]    i_m2_sel,
  input  logic          i_m2_we,
  input  logic          i_m2_stb,
  output logic [31:0]   o_m2_rdt,
  output logic          o_m2_ack,
  output logic [aw-3:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_stb,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  output logic          o_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    gnt, last, win;
  logic [CW-1:0] cnt;
  logic [2:0]    req;
  logic          tmo_hit, done, forced, ack_vld;
  logic [aw-3:0] win_adr;
  logic [31:0]   win_dat;
  logic [3:0]    win_sel;
  logic          win_we;

  assign req = {i_m2_stb, i_m1_stb, i_m0_stb};

  // Scan order starts just after the previous winner.
  always_comb begin
    win = 2'd0;
    case (last)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_adr = i_m0_adr;
    win_dat = i_m0_dat;
    win_sel = i_m0_sel;
    win_we  = i_m0_we;
    case (win)
      2'd1: begin
        win_adr = i_m1_adr;
        win_dat = i_m1_dat;
        win_sel = i_m1_sel;
        win_we  = i_m1_we;
      end
      2'd2: begin
        win_adr = i_m2_adr;
        win_dat = i_m2_dat;
        win_sel = i_m2_sel;
        win_we  = i_m2_we;
      end
      default: ;
    endcase
  end

  generate
    if (TIMEOUT != 0) begin : g_tmo
      assign tmo_hit = (cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    forced    = 1'b0;
    case (state)
      IDLE: if (|req) state_nxt = BUSY;
      BUSY: begin
        if (i_s_ack || tmo_hit) begin
          done      = 1'b1;
          forced    = ~i_s_ack;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      gnt     <= 2'd0;
      last    <= 2'd2;
      cnt     <= '0;
      o_s_adr <= '0;
      o_s_dat <= '0;
      o_s_sel <= '0;
      o_s_we  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (|req) begin
          gnt     <= win;
          last    <= win;
          cnt     <= '0;
          o_s_adr <= win_adr;
          o_s_dat <= win_dat;
          o_s_sel <= win_sel;
          o_s_we  <= win_we;
        end
      end else if (!done) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A reset cycle aborts the transfer without acknowledging the master.
  assign ack_vld   = done & ~i_rst;
  assign o_s_stb   = (state == BUSY);
  assign o_timeout = forced & ~i_rst;

  assign o_m0_ack = ack_vld && (gnt == 2'd0);
  assign o_m1_ack = ack_vld && (gnt == 2'd1);
  assign o_m2_ack = ack_vld && (gnt == 2'd2);

  assign o_m0_rdt = (o_m0_ack && i_s_ack) ? i_s_rdt : 32'd0;
  assign o_m1_rdt = (o_m1_ack && i_s_ack) ? i_s_rdt : 32'd0;
  assign o_m2_rdt = (o_m2_ack && i_s_ack) ? i_s_rdt : 32'd0;

endmodule
